// File: rtl/bt_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// bt_cmd_sequencer
//
// Brings up an RN4871 BLE module after power-on: holds its RST_N low, waits
// for it to boot, plays a fixed command script over the BT UART (waiting for
// the '>' prompt after the commands that produce one), then switches to a
// host-to-BT byte passthrough.
//
// Optional feature macro: BT_SEQ_RETRY_EN
//   defined   : a prompt timeout restarts the whole bring-up (BT reset
//               included) up to MAX_RETRY times before giving up.
//   undefined : the first prompt timeout is fatal; no retry counter exists.
//
// Ports
//   i_Clk        single clock, rising edge
//   i_Rst        synchronous active-high reset
//   o_BT_Rst_L   RN4871 RST_N drive (low only in RST_HOLD)
//   o_TX_DV      one-cycle byte strobe to the BT UART transmitter
//   o_TX_Byte    byte to the BT UART transmitter
//   i_TX_Active  BT UART transmitter busy
//   i_TX_Done    one-cycle end-of-byte pulse from the BT UART transmitter
//   i_RX_DV      BT UART receiver strobe
//   i_RX_Byte    BT UART receiver byte
//   i_Host_DV    host UART receiver strobe
//   i_Host_Byte  host UART receiver byte
//   o_Host_Drop  one-cycle pulse when a host byte is discarded
//   o_Done       configuration complete, passthrough active
//   o_Error      configuration failed (terminal until i_Rst)
//   o_State      current state encoding, for LEDs
//
// States
//   RST_HOLD    (0) | BT held in reset for RST_CLKS cycles
//   BOOT_WAIT   (1) | BT booting, BOOT_CLKS cycles
//   SEND        (2) | strobe ROM[idx] once the transmitter is idle
//   WAIT_TX     (3) | waiting for the byte to leave the transmitter
//   WAIT_PROMPT (4) | waiting for PROMPT_CHAR, bounded by TIMEOUT_CLKS
//   PASS        (5) | script done, host bytes forwarded to BT
//   FAIL        (6) | prompt never arrived, terminal
// ---------------------------------------------------------------------------
module bt_cmd_sequencer #(
  parameter int          RST_CLKS     = 25000,
  parameter int          BOOT_CLKS    = 2500000,
  parameter int          TIMEOUT_CLKS = 5000000,
  parameter int          MAX_RETRY    = 3,
  parameter logic [7:0]  PROMPT_CHAR  = 8'h3E
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_BT_Rst_L,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Host_DV,
  input  logic [7:0] i_Host_Byte,
  output logic       o_Host_Drop,
  output logic       o_Done,
  output logic       o_Error,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    RST_HOLD    = 3'd0,
    BOOT_WAIT   = 3'd1,
    SEND        = 3'd2,
    WAIT_TX     = 3'd3,
    WAIT_PROMPT = 3'd4,
    PASS        = 3'd5,
    FAIL        = 3'd6
  } state_t;

  // One shared up-counter serves the three timed states; only one of them
  // is active at a time and it clears on every state change.
  localparam int CNT_MAX_RB = (RST_CLKS > BOOT_CLKS) ? RST_CLKS : BOOT_CLKS;
  localparam int CNT_MAX    = (CNT_MAX_RB > TIMEOUT_CLKS) ? CNT_MAX_RB : TIMEOUT_CLKS;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_TC  = CNT_W'(RST_CLKS - 1);
  localparam logic [CNT_W-1:0] BOOT_TC = CNT_W'(BOOT_CLKS - 1);
  localparam logic [CNT_W-1:0] TO_TC   = CNT_W'(TIMEOUT_CLKS - 1);

  // Script: "$$$" | "SN,GOBOARD\r" | "---\r"  -> 18 bytes, index 0..17.
  localparam logic [4:0] ROM_LAST = 5'd17;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       idx, idx_nxt;
  logic [7:0]       rom_byte;
  logic             rom_wait;
  logic             seq_dv;
  logic             tx_dv_q;
  logic             hold_full;
  logic [7:0]       hold_byte;
  logic             host_issue;
  logic             host_take;
  logic             prompt_hit;
  logic             timeout;

`ifdef BT_SEQ_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0] retry_cnt, retry_nxt;
`endif

  // Command ROM; rom_wait marks the last byte of a command that answers
  // with a prompt.
  always_comb begin
    rom_byte = 8'h00;
    rom_wait = 1'b0;
    case (idx)
      5'd0:  rom_byte = 8'h24;
      5'd1:  rom_byte = 8'h24;
      5'd2:  begin rom_byte = 8'h24; rom_wait = 1'b1; end
      5'd3:  rom_byte = 8'h53;
      5'd4:  rom_byte = 8'h4E;
      5'd5:  rom_byte = 8'h2C;
      5'd6:  rom_byte = 8'h47;
      5'd7:  rom_byte = 8'h4F;
      5'd8:  rom_byte = 8'h42;
      5'd9:  rom_byte = 8'h4F;
      5'd10: rom_byte = 8'h41;
      5'd11: rom_byte = 8'h52;
      5'd12: rom_byte = 8'h44;
      5'd13: begin rom_byte = 8'h0D; rom_wait = 1'b1; end
      5'd14: rom_byte = 8'h2D;
      5'd15: rom_byte = 8'h2D;
      5'd16: rom_byte = 8'h2D;
      5'd17: rom_byte = 8'h0D;
      default: rom_byte = 8'h00;
    endcase
  end

  assign prompt_hit = i_RX_DV && (i_RX_Byte == PROMPT_CHAR);
  assign timeout    = (cnt == TO_TC);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    seq_dv    = 1'b0;
`ifdef BT_SEQ_RETRY_EN
    retry_nxt = retry_cnt;
`endif
    case (state)
      RST_HOLD: begin
        if (cnt == RST_TC) state_nxt = BOOT_WAIT;
      end
      BOOT_WAIT: begin
        if (cnt == BOOT_TC) begin
          state_nxt = SEND;
          idx_nxt   = 5'd0;
        end
      end
      SEND: begin
        // tx_dv_q keeps strobes at least one idle cycle apart.
        if (!i_TX_Active && !tx_dv_q) begin
          seq_dv    = 1'b1;
          state_nxt = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (i_TX_Done) begin
          if (rom_wait) begin
            state_nxt = WAIT_PROMPT;
          end else if (idx == ROM_LAST) begin
            state_nxt = PASS;
          end else begin
            state_nxt = SEND;
            idx_nxt   = idx + 5'd1;
          end
        end
      end
      WAIT_PROMPT: begin
        if (prompt_hit) begin
          state_nxt = SEND;
          idx_nxt   = idx + 5'd1;
        end else if (timeout) begin
`ifdef BT_SEQ_RETRY_EN
          if (retry_cnt < RTY_W'(MAX_RETRY)) begin
            retry_nxt = retry_cnt + RTY_W'(1);
            state_nxt = RST_HOLD;
            idx_nxt   = 5'd0;
          end else begin
            state_nxt = FAIL;
          end
`else
          state_nxt = FAIL;
`endif
        end
      end
      PASS:    state_nxt = PASS;
      FAIL:    state_nxt = FAIL;
      default: state_nxt = RST_HOLD;
    endcase
  end

  // Passthrough: one holding register. A release and a capture in the same
  // cycle sends the old byte and keeps the new one.
  assign host_issue = (state == PASS) && hold_full && !i_TX_Active && !tx_dv_q;
  assign host_take  = (state == PASS) && i_Host_DV && (!hold_full || host_issue);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      idx       <= 5'd0;
      tx_dv_q   <= 1'b0;
      hold_full <= 1'b0;
      hold_byte <= 8'h00;
`ifdef BT_SEQ_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      tx_dv_q <= o_TX_DV;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == RST_HOLD || state == BOOT_WAIT || state == WAIT_PROMPT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (host_take) begin
        hold_full <= 1'b1;
        hold_byte <= i_Host_Byte;
      end else if (host_issue) begin
        hold_full <= 1'b0;
      end
`ifdef BT_SEQ_RETRY_EN
      retry_cnt <= retry_nxt;
`endif
    end
  end

  // Strobes are gated by i_Rst so they drop in the very cycle reset is seen.
  assign o_TX_DV     = !i_Rst && (seq_dv || host_issue);
  assign o_Host_Drop = !i_Rst && i_Host_DV && !host_take;

  always_comb begin
    o_TX_Byte = 8'h00;
    if (!i_Rst) begin
      if (state == SEND)      o_TX_Byte = rom_byte;
      else if (state == PASS) o_TX_Byte = hold_byte;
    end
  end

  assign o_BT_Rst_L = (state != RST_HOLD);
  assign o_Done     = (state == PASS);
  assign o_Error    = (state == FAIL);
  assign o_State    = state;

endmodule

// File: tb/tb_bt_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bt_cmd_sequencer
//
// Directed bench for bt_cmd_sequencer. Expected TX bytes are queued by the
// stimulus; an independent monitor pops and compares on every o_TX_DV.
// Honours BT_SEQ_RETRY_EN for the no-prompt scenario.
// ---------------------------------------------------------------------------
module tb_bt_cmd_sequencer;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       o_BT_Rst_L;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Active;
  logic       i_TX_Done;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic       i_Host_DV = 1'b0;
  logic [7:0] i_Host_Byte = 8'h00;
  logic       o_Host_Drop;
  logic       o_Done;
  logic       o_Error;
  logic [2:0] o_State;

  bt_cmd_sequencer #(
    .RST_CLKS    (4),
    .BOOT_CLKS   (8),
    .TIMEOUT_CLKS(50),
    .MAX_RETRY   (2),
    .PROMPT_CHAR (8'h3E)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (i_Rst),
    .o_BT_Rst_L (o_BT_Rst_L),
    .o_TX_DV    (o_TX_DV),
    .o_TX_Byte  (o_TX_Byte),
    .i_TX_Active(i_TX_Active),
    .i_TX_Done  (i_TX_Done),
    .i_RX_DV    (i_RX_DV),
    .i_RX_Byte  (i_RX_Byte),
    .i_Host_DV  (i_Host_DV),
    .i_Host_Byte(i_Host_Byte),
    .o_Host_Drop(o_Host_Drop),
    .o_Done     (o_Done),
    .o_Error    (o_Error),
    .o_State    (o_State)
  );

  always #5 clk = ~clk;

  // TX model: busy for 10 cycles after a strobe, Done on the last one.
  logic       tx_busy = 1'b0;
  logic [3:0] tx_cnt  = 4'd0;
  always @(posedge clk) begin
    if (o_TX_DV && !tx_busy) begin
      tx_busy <= 1'b1;
      tx_cnt  <= 4'd9;
    end else if (tx_busy) begin
      if (tx_cnt == 4'd0) tx_busy <= 1'b0;
      else                tx_cnt  <= tx_cnt - 4'd1;
    end
  end
  assign i_TX_Active = tx_busy;
  assign i_TX_Done   = tx_busy && (tx_cnt == 4'd0);

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] script [18] = '{8'h24, 8'h24, 8'h24, 8'h53, 8'h4E, 8'h2C, 8'h47, 8'h4F, 8'h42,
                              8'h4F, 8'h41, 8'h52, 8'h44, 8'h0D, 8'h2D, 8'h2D, 8'h2D, 8'h0D};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the queue, never follow
  // another strobe directly and never occur while the transmitter is busy.
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (o_TX_DV === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", {24'h0, o_TX_Byte}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'h0, o_TX_Byte}, {24'h0, exp_q.pop_front()});
      end
      chk("tx_dv_while_active", {31'h0, i_TX_Active}, 0);
      chk("tx_dv_back2back", {31'h0, prev_dv}, 0);
    end
    prev_dv = o_TX_DV;
  end

  int falls;
  int last4;

  task automatic push_script();
    for (int i = 0; i < 18; i++) exp_q.push_back(script[i]);
  endtask

  task automatic push_dollars(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'h24);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    i_Rst = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge after reset has been clocked; releases it and
  // counts the cycles RST_N stays low.
  task automatic release_and_count();
    int lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_BT_Rst_L) break;
      lows++;
      if (i == 0) i_Rst = 1'b0;
      @(negedge clk);
    end
    chk("rst_low_clks", lows, 4);
  endtask

  // mode 0: '>' after each prompt wait; 1: 'C','M','D' then '>'; 2: silent.
  // stop_on 0: o_Done; 1: WAIT_PROMPT; 2: o_Error.
  task automatic run(input int mode, input int budget, input int stop_on);
    int   pw = 0;
    int   c4 = 0;
    bit   hit = 0;
    bit   exp_stay = 0;
    bit   exp_adv = 0;
    logic prev_rl;
    falls   = 0;
    last4   = 0;
    prev_rl = o_BT_Rst_L;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      i_RX_DV   = 1'b0;
      i_RX_Byte = 8'h00;
      if (exp_stay) begin chk("cmd_ignored", o_State, 4); exp_stay = 0; end
      if (exp_adv)  begin chk("prompt_adv",  o_State, 2); exp_adv  = 0; end
      if (prev_rl && !o_BT_Rst_L) falls++;
      prev_rl = o_BT_Rst_L;
      if (o_State == 3'd4) begin
        c4++; pw++;
      end else begin
        if (c4 != 0) last4 = c4;
        c4 = 0; pw = 0;
      end
      if ((stop_on == 0 && o_Done) || (stop_on == 1 && o_State == 3'd4) ||
          (stop_on == 2 && o_Error)) begin
        hit = 1;
        break;
      end
      if (o_State == 3'd4) begin
        if (mode == 0 && pw == 2) begin
          i_RX_DV = 1'b1; i_RX_Byte = 8'h3E; exp_adv = 1;
        end else if (mode == 1) begin
          case (pw)
            2: begin i_RX_DV = 1'b1; i_RX_Byte = 8'h43; exp_stay = 1; end
            4: begin i_RX_DV = 1'b1; i_RX_Byte = 8'h4D; exp_stay = 1; end
            6: begin i_RX_DV = 1'b1; i_RX_Byte = 8'h44; exp_stay = 1; end
            8: begin i_RX_DV = 1'b1; i_RX_Byte = 8'h3E; exp_adv  = 1; end
            default: ;
          endcase
        end
      end
    end
    chk("run_reached", {31'h0, hit}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and normal bring-up with immediate prompts.
    do_reset(3);
    chk("rst_state",  o_State, 0);
    chk("rst_rst_l",  {31'h0, o_BT_Rst_L}, 0);
    chk("rst_tx_dv",  {31'h0, o_TX_DV}, 0);
    chk("rst_tx_byte", {24'h0, o_TX_Byte}, 0);
    chk("rst_done",   {31'h0, o_Done}, 0);
    chk("rst_error",  {31'h0, o_Error}, 0);
    push_script();
    release_and_count();
    run(0, 1000, 0);
    chk("pass_state", o_State, 5);
    chk("pass_error", {31'h0, o_Error}, 0);
    chk("pass_rst_l", {31'h0, o_BT_Rst_L}, 1);

    // Noise bytes before the prompt are ignored.
    do_reset(3);
    push_script();
    release_and_count();
    run(1, 1000, 0);
    chk("pass2_done", {31'h0, o_Done}, 1);

    // Passthrough: A5, then 5A two cycles later (held), then 77 dropped.
    repeat (2) @(negedge clk);
    i_Host_DV = 1'b1; i_Host_Byte = 8'hA5; exp_q.push_back(8'hA5);
    #1 chk("host_a5_drop", {31'h0, o_Host_Drop}, 0);
    @(negedge clk);
    i_Host_DV = 1'b0;
    @(negedge clk);
    i_Host_DV = 1'b1; i_Host_Byte = 8'h5A; exp_q.push_back(8'h5A);
    #1 chk("host_5a_drop", {31'h0, o_Host_Drop}, 0);
    @(negedge clk);
    i_Host_DV = 1'b1; i_Host_Byte = 8'h77;
    #1 chk("host_full_drop", {31'h0, o_Host_Drop}, 1);
    chk("host_held", {31'h0, o_TX_DV}, 0);
    @(negedge clk);
    i_Host_DV = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("host_drain", exp_q.size(), 0);

    // Host byte during BOOT_WAIT is dropped.
    do_reset(3);
    push_dollars(3);
    release_and_count();
    chk("boot_state", o_State, 1);
    i_Host_DV = 1'b1; i_Host_Byte = 8'h11;
    #1 chk("boot_drop", {31'h0, o_Host_Drop}, 1);
    chk("boot_no_dv", {31'h0, o_TX_DV}, 0);
    @(negedge clk);
    i_Host_DV = 1'b0;

    // Reset pulse during WAIT_PROMPT.
    run(2, 500, 1);
    i_Rst = 1'b1; i_Host_DV = 1'b1; i_Host_Byte = 8'h22;
    @(negedge clk);
    chk("abort_state",   o_State, 0);
    chk("abort_rst_l",   {31'h0, o_BT_Rst_L}, 0);
    chk("abort_tx_dv",   {31'h0, o_TX_DV}, 0);
    chk("abort_tx_byte", {24'h0, o_TX_Byte}, 0);
    chk("abort_drop",    {31'h0, o_Host_Drop}, 0);
    chk("abort_done",    {31'h0, o_Done}, 0);
    chk("abort_error",   {31'h0, o_Error}, 0);
    i_Host_DV = 1'b0;

    // No prompt ever: retries (if enabled), then FAIL.
`ifdef BT_SEQ_RETRY_EN
    push_dollars(9);
`else
    push_dollars(3);
`endif
    release_and_count();
    run(2, 3000, 2);
`ifdef BT_SEQ_RETRY_EN
    chk("bt_resets_total", falls + 1, 3);
`else
    chk("bt_resets_total", falls + 1, 1);
`endif
    chk("timeout_clks", last4, 50);
    repeat (20) @(negedge clk);
    chk("fail_state", o_State, 6);
    chk("fail_error", {31'h0, o_Error}, 1);
    chk("fail_done",  {31'h0, o_Done}, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
